// File: rtl/obi_pkg.sv
// ============================================================================
// obi_pkg : shared OBI types, default widths and manager state encoding
// Rev 1.0
// ============================================================================
`default_nettype none

package obi_pkg;

    localparam int OBI_ADDR_WIDTH = 32;
    localparam int OBI_DATA_WIDTH = 32;
    localparam int OBI_BE_WIDTH   = OBI_DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ADDR   = 2'd1,
        ST_WAIT_R = 2'd2,
        ST_RESP   = 2'd3
    } obi_mgr_state_t;

    typedef struct packed {
        logic [OBI_ADDR_WIDTH-1:0] addr;
        logic                      we;
        logic [OBI_BE_WIDTH-1:0]   be;
        logic [OBI_DATA_WIDTH-1:0] wdata;
    } obi_a_chan_t;

    typedef struct packed {
        logic [OBI_DATA_WIDTH-1:0] rdata;
    } obi_r_chan_t;

endpackage

`default_nettype wire

// File: rtl/obi_timeout_cnt.sv
// ============================================================================
// obi_timeout_cnt : clearable wait counter, flags the last allowed wait cycle
// Rev 1.0
// ============================================================================
`default_nettype none

module obi_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic hit
);

    localparam int CNT_W = (TIMEOUT_CYCLES <= 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam int c_TERM_INT = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
    localparam logic [CNT_W-1:0] c_TERM = CNT_W'(c_TERM_INT);
    localparam bit c_ENABLED = (TIMEOUT_CYCLES != 0);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt <= '0;
        end else if (en) begin
            if (r_cnt == c_TERM) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // hit marks the TIMEOUT_CYCLES-th consecutive cycle spent waiting
    assign hit = c_ENABLED && en && (r_cnt == c_TERM);

endmodule

`default_nettype wire

// File: rtl/obi_manager.sv
// ============================================================================
// obi_manager : single-outstanding OBI initiator with local cmd/rsp ports
// Rev 1.0
// ============================================================================
`default_nettype none

module obi_manager
    import obi_pkg::*;
#(
    parameter int ADDR_WIDTH     = OBI_ADDR_WIDTH,
    parameter int DATA_WIDTH     = OBI_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk_i,
    input  logic                    rst_i,

    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
    input  logic                    cmd_we_i,
    input  logic [DATA_WIDTH/8-1:0] cmd_be_i,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata_i,

    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
    output logic                    rsp_err_o,

    output logic                    obi_req_o,
    input  logic                    obi_gnt_i,
    output logic [ADDR_WIDTH-1:0]   obi_addr_o,
    output logic                    obi_we_o,
    output logic [DATA_WIDTH/8-1:0] obi_be_o,
    output logic [DATA_WIDTH-1:0]   obi_wdata_o,
    input  logic                    obi_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   obi_rdata_i
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;

    obi_mgr_state_t          r_state, w_state_next;
    logic                    r_req, w_req_next;
    logic [ADDR_WIDTH-1:0]   r_addr, w_addr_next;
    logic                    r_we, w_we_next;
    logic [BE_WIDTH-1:0]     r_be, w_be_next;
    logic [DATA_WIDTH-1:0]   r_wdata, w_wdata_next;
    logic                    r_rsp_valid, w_rsp_valid_next;
    logic [DATA_WIDTH-1:0]   r_rdata, w_rdata_next;
    logic                    r_err, w_err_next;

    logic w_cnt_clr;
    logic w_cnt_en;
    logic w_cnt_hit;

    // Counter restarts on the way into ADDR (from IDLE) and into WAIT_R (on gnt)
    assign w_cnt_clr = (r_state == ST_IDLE) || ((r_state == ST_ADDR) && obi_gnt_i);
    assign w_cnt_en  = (r_state == ST_ADDR) || (r_state == ST_WAIT_R);

    obi_timeout_cnt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk (clk_i),
        .rst (rst_i),
        .clr (w_cnt_clr),
        .en  (w_cnt_en),
        .hit (w_cnt_hit)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_req       <= 1'b0;
            r_addr      <= '0;
            r_we        <= 1'b0;
            r_be        <= '0;
            r_wdata     <= '0;
            r_rsp_valid <= 1'b0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_req       <= w_req_next;
            r_addr      <= w_addr_next;
            r_we        <= w_we_next;
            r_be        <= w_be_next;
            r_wdata     <= w_wdata_next;
            r_rsp_valid <= w_rsp_valid_next;
            r_rdata     <= w_rdata_next;
            r_err       <= w_err_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_req_next       = r_req;
        w_addr_next      = r_addr;
        w_we_next        = r_we;
        w_be_next        = r_be;
        w_wdata_next     = r_wdata;
        w_rsp_valid_next = r_rsp_valid;
        w_rdata_next     = r_rdata;
        w_err_next       = r_err;

        case (r_state)
            ST_IDLE: begin
                if (cmd_valid_i) begin
                    w_addr_next  = cmd_addr_i;
                    w_we_next    = cmd_we_i;
                    w_be_next    = cmd_be_i;
                    w_wdata_next = cmd_wdata_i;
                    w_req_next   = 1'b1;
                    w_state_next = ST_ADDR;
                end
            end
            ST_ADDR: begin
                // A grant arriving on the timeout cycle still completes normally
                if (obi_gnt_i) begin
                    w_req_next   = 1'b0;
                    w_state_next = ST_WAIT_R;
                end else if (w_cnt_hit) begin
                    w_req_next       = 1'b0;
                    w_rsp_valid_next = 1'b1;
                    w_rdata_next     = '0;
                    w_err_next       = 1'b1;
                    w_state_next     = ST_RESP;
                end
            end
            ST_WAIT_R: begin
                if (obi_rvalid_i) begin
                    w_rsp_valid_next = 1'b1;
                    w_rdata_next     = r_we ? '0 : obi_rdata_i;
                    w_err_next       = 1'b0;
                    w_state_next     = ST_RESP;
                end else if (w_cnt_hit) begin
                    w_rsp_valid_next = 1'b1;
                    w_rdata_next     = '0;
                    w_err_next       = 1'b1;
                    w_state_next     = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    w_rsp_valid_next = 1'b0;
                    w_rdata_next     = '0;
                    w_err_next       = 1'b0;
                    w_state_next     = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_req_next   = 1'b0;
            end
        endcase
    end

    assign cmd_ready_o = (r_state == ST_IDLE);
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_rdata_o = r_rdata;
    assign rsp_err_o   = r_err;
    assign obi_req_o   = r_req;
    assign obi_addr_o  = r_addr;
    assign obi_we_o    = r_we;
    assign obi_be_o    = r_be;
    assign obi_wdata_o = r_wdata;

endmodule

`default_nettype wire

// File: tb/tb_obi_manager.sv
// ============================================================================
// tb_obi_manager : directed stimulus with a response scoreboard for obi_manager
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_obi_manager;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic        cmd_we;
    logic [3:0]  cmd_be;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        obi_req;
    logic        obi_gnt;
    logic [31:0] obi_addr;
    logic        obi_we;
    logic [3:0]  obi_be;
    logic [31:0] obi_wdata;
    logic        obi_rvalid;
    logic [31:0] obi_rdata;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_exp    = 0;
    int   n_rsp    = 0;

    obi_manager #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_addr_i   (cmd_addr),
        .cmd_we_i     (cmd_we),
        .cmd_be_i     (cmd_be),
        .cmd_wdata_i  (cmd_wdata),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_rdata_o  (rsp_rdata),
        .rsp_err_o    (rsp_err),
        .obi_req_o    (obi_req),
        .obi_gnt_i    (obi_gnt),
        .obi_addr_o   (obi_addr),
        .obi_we_o     (obi_we),
        .obi_be_o     (obi_be),
        .obi_wdata_o  (obi_wdata),
        .obi_rvalid_i (obi_rvalid),
        .obi_rdata_i  (obi_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every accepted response is matched against the queue
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rsp: got rdata 0x%0h err %0b, expected none", rsp_rdata, rsp_err);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("rsp_rdata", {32'h0, rsp_rdata}, {32'h0, e.rdata});
                check("rsp_err", {63'h0, rsp_err}, {63'h0, e.err});
            end
            n_rsp++;
        end
    end

    task automatic issue_cmd(input logic [31:0] addr, input logic we, input logic [3:0] be,
                             input logic [31:0] wdata, input logic [31:0] exp_rdata,
                             input logic exp_err, input bit push);
        int k;
        cmd_valid = 1'b1;
        cmd_addr  = addr;
        cmd_we    = we;
        cmd_be    = be;
        cmd_wdata = wdata;
        k = 0;
        while (!cmd_ready && k < 20) begin
            tick();
            k++;
        end
        check("cmd_ready_wait", {63'h0, cmd_ready}, 64'h1);
        if (push) begin
            exp_q.push_back('{rdata: exp_rdata, err: exp_err});
            n_exp++;
        end
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic a_phase(input int gnt_delay, input logic [31:0] addr, input logic we,
                           input logic [3:0] be, input logic [31:0] wdata);
        for (int i = 0; i <= gnt_delay; i++) begin
            check("a_req", {63'h0, obi_req}, 64'h1);
            check("a_addr", {32'h0, obi_addr}, {32'h0, addr});
            check("a_we", {63'h0, obi_we}, {63'h0, we});
            check("a_be", {60'h0, obi_be}, {60'h0, be});
            check("a_wdata", {32'h0, obi_wdata}, {32'h0, wdata});
            if (i == gnt_delay) obi_gnt = 1'b1;
            tick();
        end
        obi_gnt = 1'b0;
        check("a_req_drop", {63'h0, obi_req}, 64'h0);
    endtask

    task automatic r_phase(input int rv_delay, input logic [31:0] rdata);
        for (int i = 0; i < rv_delay; i++) begin
            check("r_no_rsp", {63'h0, rsp_valid}, 64'h0);
            tick();
        end
        obi_rvalid = 1'b1;
        obi_rdata  = rdata;
        tick();
        obi_rvalid = 1'b0;
        obi_rdata  = '0;
        check("r_rsp_valid", {63'h0, rsp_valid}, 64'h1);
    endtask

    task automatic wait_rsp();
        int k;
        k = 0;
        while (n_rsp < n_exp && k < 30) begin
            tick();
            k++;
        end
        check("rsp_count", 64'(n_rsp), 64'(n_exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_addr   = '0;
        cmd_we     = 1'b0;
        cmd_be     = '0;
        cmd_wdata  = '0;
        rsp_ready  = 1'b1;
        obi_gnt    = 1'b0;
        obi_rvalid = 1'b0;
        obi_rdata  = '0;

        repeat (3) tick();
        check("rst_cmd_ready", {63'h0, cmd_ready}, 64'h1);
        check("rst_req", {63'h0, obi_req}, 64'h0);
        check("rst_rsp_valid", {63'h0, rsp_valid}, 64'h0);
        check("rst_addr", {32'h0, obi_addr}, 64'h0);
        check("rst_rdata", {32'h0, rsp_rdata}, 64'h0);
        check("rst_err", {63'h0, rsp_err}, 64'h0);
        rst = 1'b0;
        tick();

        // Read, immediate grant, data one cycle later
        issue_cmd(32'h10, 1'b0, 4'hF, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);
        a_phase(0, 32'h10, 1'b0, 4'hF, 32'h0);
        r_phase(0, 32'hDEADBEEF);
        wait_rsp();

        // Write with grant delayed three cycles; bus rdata must not leak into rsp
        issue_cmd(32'h20, 1'b1, 4'b1100, 32'hA5A5_0000, 32'h0, 1'b0, 1'b1);
        a_phase(3, 32'h20, 1'b1, 4'b1100, 32'hA5A5_0000);
        r_phase(1, 32'hFFFF_FFFF);
        wait_rsp();

        // Response backpressure with a pending command held off
        rsp_ready = 1'b0;
        issue_cmd(32'h30, 1'b0, 4'hF, 32'h0, 32'h3C3C_0001, 1'b0, 1'b1);
        a_phase(0, 32'h30, 1'b0, 4'hF, 32'h0);
        r_phase(0, 32'h3C3C_0001);
        cmd_valid = 1'b1;
        cmd_addr  = 32'h34;
        cmd_we    = 1'b0;
        cmd_be    = 4'hF;
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp_valid", {63'h0, rsp_valid}, 64'h1);
            check("bp_rdata", {32'h0, rsp_rdata}, 64'h3C3C_0001);
            check("bp_cmd_ready", {63'h0, cmd_ready}, 64'h0);
            check("bp_req", {63'h0, obi_req}, 64'h0);
            tick();
        end
        rsp_ready = 1'b1;
        issue_cmd(32'h34, 1'b0, 4'hF, 32'h0, 32'h0000_5678, 1'b0, 1'b1);
        a_phase(0, 32'h34, 1'b0, 4'hF, 32'h0);
        r_phase(0, 32'h0000_5678);
        wait_rsp();

        // Timeout on a grant that never comes, then a stray rvalid
        issue_cmd(32'h40, 1'b0, 4'hF, 32'h0, 32'h0, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) begin
            check("to_req_high", {63'h0, obi_req}, 64'h1);
            check("to_addr", {32'h0, obi_addr}, 64'h40);
            tick();
        end
        check("to_req_drop", {63'h0, obi_req}, 64'h0);
        check("to_rsp_valid", {63'h0, rsp_valid}, 64'h1);
        check("to_rsp_err", {63'h0, rsp_err}, 64'h1);
        obi_rvalid = 1'b1;
        obi_rdata  = 32'h0000_0777;
        tick();
        check("stray_rsp_valid0", {63'h0, rsp_valid}, 64'h0);
        tick();
        check("stray_rsp_valid1", {63'h0, rsp_valid}, 64'h0);
        obi_rvalid = 1'b0;
        obi_rdata  = '0;
        check("stray_no_second", 64'(n_rsp), 64'(n_exp));

        // rvalid coinciding with gnt is ignored; the later one is captured
        issue_cmd(32'h50, 1'b0, 4'hF, 32'h0, 32'h0000_1234, 1'b0, 1'b1);
        check("gr_req", {63'h0, obi_req}, 64'h1);
        obi_gnt    = 1'b1;
        obi_rvalid = 1'b1;
        obi_rdata  = 32'hBAD0_BAD0;
        tick();
        obi_gnt    = 1'b0;
        obi_rvalid = 1'b0;
        obi_rdata  = '0;
        check("gr_req_drop", {63'h0, obi_req}, 64'h0);
        check("gr_no_rsp0", {63'h0, rsp_valid}, 64'h0);
        tick();
        check("gr_no_rsp1", {63'h0, rsp_valid}, 64'h0);
        obi_rvalid = 1'b1;
        obi_rdata  = 32'h0000_1234;
        tick();
        obi_rvalid = 1'b0;
        obi_rdata  = '0;
        check("gr_rsp_valid", {63'h0, rsp_valid}, 64'h1);
        wait_rsp();

        // Reset while waiting for R; the abandoned read yields no response
        issue_cmd(32'h60, 1'b0, 4'hF, 32'h0, 32'h0, 1'b0, 1'b0);
        a_phase(0, 32'h60, 1'b0, 4'hF, 32'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_req", {63'h0, obi_req}, 64'h0);
        check("mrst_rsp_valid", {63'h0, rsp_valid}, 64'h0);
        check("mrst_cmd_ready", {63'h0, cmd_ready}, 64'h1);
        issue_cmd(32'h70, 1'b0, 4'hF, 32'h0, 32'hCAFE_F00D, 1'b0, 1'b1);
        a_phase(0, 32'h70, 1'b0, 4'hF, 32'h0);
        r_phase(0, 32'hCAFE_F00D);
        wait_rsp();

        tick();
        check("queue_empty", 64'(exp_q.size()), 64'h0);
        check("final_rsp_count", 64'(n_rsp), 64'(n_exp));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
